sm83_irq_ctrl: RTL and testbench

- Parametrised interrupt controller for the sm83 core: IF/IE registers, IME with EI delay, HALT wake-up and a 5-M-cycle dispatch sequence.
- Sits beside the sequencer: requests dispatch at instruction boundaries, then supplies the vector written into PC.
- Generalises the fixed 5-source scheme to N_IRQ sources with configurable vector base and stride.

---
 rtl/sm83_pkg.sv | 26 ++
 rtl/irq_prio_enc.sv | 25 ++
 rtl/sm83_irq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_sm83_irq_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm83_pkg.sv
// sm83_pkg -- shared types and constants for the sm83 interrupt controller.
//   irq_state_t : controller state (idle, halted, dispatching)
//   DISP_SAMPLE : dispatch M-cycle in which the serviced source is chosen
//   DISP_LAST   : final dispatch M-cycle (vector handed to the sequencer)
//   irq_vector  : vector address for a source index, 16-bit wrapping
package sm83_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE     = 2'd0,
        IRQ_HALTED   = 2'd1,
        IRQ_DISPATCH = 2'd2
    } irq_state_t;

    localparam logic [2:0] DISP_SAMPLE = 3'd3;
    localparam logic [2:0] DISP_LAST   = 3'd4;

    // base + idx*stride, truncated to 16 bits so large strides wrap.
    function automatic logic [15:0] irq_vector(input logic [15:0] base,
                                               input logic [15:0] stride,
                                               input logic [2:0]  idx);
        logic [15:0] off;
        off = stride * {13'd0, idx};
        return base + off;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc -- fixed-priority encoder, lowest set index wins.
//   req : request vector (N bits, N <= 8)
//   idx : index of the lowest set bit (0 when none)
//   any : at least one request set
module irq_prio_enc #(
    parameter int unsigned N = 5
) (
    input  logic [N-1:0] req,
    output logic [2:0]   idx,
    output logic         any
);

    // Scan from the top down so the lowest set index is the last writer.
    always_comb begin
        idx = 3'd0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sm83_irq_ctrl.sv
// sm83_irq_ctrl -- interrupt controller for the sm83 core.
// Holds IF/IE, the master enable with its one-instruction EI delay, HALT
// entry/exit (including the HALT bug) and the 5 M-cycle dispatch sequence.
//   clk, rst           : core clock (one M-cycle per clock), async active-high reset
//   irq_src            : raw source lines, rising-edge sensitive
//   if_wr/ie_wr/wdata  : register writes; if_rdata/ie_rdata readback
//   ei/di/reti         : IME control pulses from the sequencer
//   instr_boundary     : sequencer is about to fetch the next opcode
//   halt_req           : HALT executed; halted / halt_bug report the outcome
//   int_req/int_ack    : dispatch handshake at an instruction boundary
//   disp_step          : current dispatch M-cycle 0..4
//   vector/vector_valid: target PC, presented in the last dispatch M-cycle
//   ime                : master interrupt enable
module sm83_irq_ctrl
    import sm83_pkg::*;
#(
    parameter int unsigned N_IRQ      = 5,
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter logic [15:0] VEC_STRIDE = 16'd8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_src,
    input  logic             if_wr,
    input  logic             ie_wr,
    input  logic [7:0]       wdata,
    output logic [7:0]       if_rdata,
    output logic [7:0]       ie_rdata,
    input  logic             ei,
    input  logic             di,
    input  logic             reti,
    input  logic             instr_boundary,
    input  logic             halt_req,
    output logic             halted,
    output logic             halt_bug,
    output logic             int_req,
    input  logic             int_ack,
    output logic [2:0]       disp_step,
    output logic [15:0]      vector,
    output logic             vector_valid,
    output logic             ime
);

    irq_state_t       state;
    logic [N_IRQ-1:0] src_q;
    logic [N_IRQ-1:0] if_q;
    logic [N_IRQ-1:0] if_nxt;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] pend;
    logic [7:0]       ie_q;
    logic             ime_arm;
    logic [2:0]       pend_idx;
    logic             pend_any;
    logic [2:0]       sel_idx;
    logic             sel_valid;

    assign rise = irq_src & ~src_q;
    assign pend = if_q & ie_q[N_IRQ-1:0];

    // One encoder serves the boundary request, the HALT decisions and the
    // step-3 latch; all of them look at the live pending set.
    irq_prio_enc #(.N(N_IRQ)) u_prio (
        .req (pend),
        .idx (pend_idx),
        .any (pend_any)
    );

    // Registered ime keeps the instruction after EI out of reach of dispatch.
    assign int_req  = (state == IRQ_IDLE) && instr_boundary && ime && pend_any;
    assign halted   = (state == IRQ_HALTED);
    assign ie_rdata = ie_q;

    always_comb begin
        if_rdata              = 8'hFF;
        if_rdata[N_IRQ-1:0]   = if_q;
    end

    // IF priority: dispatch clear < register write < fresh edge.
    always_comb begin
        if_nxt = if_q;
        if (state == IRQ_DISPATCH && disp_step == DISP_LAST && sel_valid) begin
            for (int i = 0; i < int'(N_IRQ); i++) begin
                if (sel_idx == 3'(i)) if_nxt[i] = 1'b0;
            end
        end
        if (if_wr) if_nxt = wdata[N_IRQ-1:0];
        if_nxt = if_nxt | rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IRQ_IDLE;
            src_q        <= irq_src;   // no spurious edge at reset release
            if_q         <= '0;
            ie_q         <= '0;
            ime          <= 1'b0;
            ime_arm      <= 1'b0;
            disp_step    <= 3'd0;
            sel_idx      <= 3'd0;
            sel_valid    <= 1'b0;
            vector       <= 16'h0000;
            vector_valid <= 1'b0;
            halt_bug     <= 1'b0;
        end else begin
            src_q        <= irq_src;
            if_q         <= if_nxt;
            halt_bug     <= 1'b0;
            vector       <= 16'h0000;
            vector_valid <= 1'b0;
            if (ie_wr) ie_q <= wdata;

            if (di) begin
                ime     <= 1'b0;
                ime_arm <= 1'b0;
            end else begin
                if (ei && state != IRQ_DISPATCH) ime_arm <= 1'b1;
                if (!ei && instr_boundary && ime_arm) begin
                    ime     <= 1'b1;
                    ime_arm <= 1'b0;
                end
                if (reti) ime <= 1'b1;
            end

            case (state)
                IRQ_IDLE: begin
                    if (int_ack && int_req) begin
                        state     <= IRQ_DISPATCH;
                        disp_step <= 3'd0;
                        ime       <= 1'b0;
                    end else if (halt_req) begin
                        // HALT with interrupts disabled but one pending never
                        // stalls; the next opcode byte is fetched twice instead.
                        if (!ime && pend_any) halt_bug <= 1'b1;
                        else                  state    <= IRQ_HALTED;
                    end
                end
                IRQ_HALTED: begin
                    if (pend_any) state <= IRQ_IDLE;
                end
                IRQ_DISPATCH: begin
                    // IE may have been rewritten by the PCH push, so the source
                    // is chosen late; the vector is registered for step 4.
                    if (disp_step == DISP_SAMPLE) begin
                        sel_idx      <= pend_idx;
                        sel_valid    <= pend_any;
                        vector_valid <= 1'b1;
                        vector       <= pend_any ? irq_vector(VEC_BASE, VEC_STRIDE, pend_idx)
                                                 : 16'h0000;
                    end
                    if (disp_step == DISP_LAST) begin
                        state     <= IRQ_IDLE;
                        disp_step <= 3'd0;
                    end else begin
                        disp_step <= disp_step + 3'd1;
                    end
                end
                default: state <= IRQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// tb_sm83_irq_ctrl -- bench for sm83_irq_ctrl: directed scenarios on a
// 5-source and an 8-source instance, then randomized traffic on the
// 5-source instance compared every cycle with a behavioural model.
module tb_sm83_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  src = 8'h00;
    logic        if_wr = 1'b0, ie_wr = 1'b0, ei = 1'b0, di = 1'b0, reti = 1'b0;
    logic        bnd = 1'b0, halt_req = 1'b0, int_ack = 1'b0;
    logic [7:0]  wdata = 8'h00;

    logic [7:0]  a_if_rdata, a_ie_rdata, b_if_rdata, b_ie_rdata;
    logic        a_halted, a_halt_bug, a_int_req, a_vv, a_ime;
    logic        b_halted, b_halt_bug, b_int_req, b_vv, b_ime;
    logic [2:0]  a_disp_step, b_disp_step;
    logic [15:0] a_vector, b_vector;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sm83_irq_ctrl #(.N_IRQ(5)) dut_a (
        .clk(clk), .rst(rst), .irq_src(src[4:0]),
        .if_wr(if_wr), .ie_wr(ie_wr), .wdata(wdata),
        .if_rdata(a_if_rdata), .ie_rdata(a_ie_rdata),
        .ei(ei), .di(di), .reti(reti), .instr_boundary(bnd), .halt_req(halt_req),
        .halted(a_halted), .halt_bug(a_halt_bug), .int_req(a_int_req), .int_ack(int_ack),
        .disp_step(a_disp_step), .vector(a_vector), .vector_valid(a_vv), .ime(a_ime)
    );

    sm83_irq_ctrl #(.N_IRQ(8), .VEC_BASE(16'h0100), .VEC_STRIDE(16'd4)) dut_b (
        .clk(clk), .rst(rst), .irq_src(src),
        .if_wr(if_wr), .ie_wr(ie_wr), .wdata(wdata),
        .if_rdata(b_if_rdata), .ie_rdata(b_ie_rdata),
        .ei(ei), .di(di), .reti(reti), .instr_boundary(bnd), .halt_req(halt_req),
        .halted(b_halted), .halt_bug(b_halt_bug), .int_req(b_int_req), .int_ack(int_ack),
        .disp_step(b_disp_step), .vector(b_vector), .vector_valid(b_vv), .ime(b_ime)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic quiet();
        if_wr = 1'b0; ie_wr = 1'b0; ei = 1'b0; di = 1'b0; reti = 1'b0;
        bnd = 1'b0; halt_req = 1'b0; int_ack = 1'b0;
    endtask

    // Accept a dispatch on instance A now and run to step 4; optionally clear
    // IE during step 2.
    task automatic dispatch_a(input string tag, input bit clr_ie);
        bnd = 1'b1;
        #1;
        chk({tag, "_req"}, 32'(a_int_req), 32'd1);
        int_ack = 1'b1;
        nxt();
        bnd = 1'b0; int_ack = 1'b0;
        chk({tag, "_ime0"}, 32'(a_ime), 32'd0);
        for (int s = 1; s <= 4; s++) begin
            nxt();
            ie_wr = 1'b0;
            if (s == 2 && clr_ie) begin ie_wr = 1'b1; wdata = 8'h00; end
        end
        chk({tag, "_step"}, 32'(a_disp_step), 32'd4);
        chk({tag, "_vv"}, 32'(a_vv), 32'd1);
    endtask

    // Behavioural model of instance A (5 sources, base 0x40, stride 8).
    int m_if, m_ie, m_prev, m_disp, m_sel;
    bit m_ime, m_arm, m_halt, m_hbug;

    function automatic int lowest(input int p);
        for (int i = 0; i < 5; i++) if (p[i]) return i;
        return -1;
    endfunction

    initial begin
        quiet();
        repeat (2) nxt();
        #1;
        chk("rst_if", 32'(a_if_rdata), 32'hE0);
        chk("rst_ie", 32'(a_ie_rdata), 32'h00);
        chk("rst_ime", 32'(a_ime), 32'd0);
        chk("rst_halted", 32'(a_halted), 32'd0);
        chk("rst_hbug", 32'(a_halt_bug), 32'd0);
        chk("rst_req", 32'(a_int_req), 32'd0);
        chk("rst_step", 32'(a_disp_step), 32'd0);
        chk("rst_vv", 32'(a_vv), 32'd0);
        chk("rst_vec", 32'(a_vector), 32'd0);
        chk("rst_b_if", 32'(b_if_rdata), 32'h00);
        nxt();
        rst = 1'b0;

        // Single source, highest priority.
        ie_wr = 1'b1; wdata = 8'h01; nxt(); ie_wr = 1'b0;
        reti = 1'b1; nxt(); reti = 1'b0;
        chk("t1_ime", 32'(a_ime), 32'd1);
        src[0] = 1'b1; nxt(); src[0] = 1'b0;
        chk("t1_if", 32'(a_if_rdata), 32'hE1);
        dispatch_a("t1", 1'b0);
        chk("t1_vec", 32'(a_vector), 32'h0040);
        nxt();
        chk("t1_if_clr", 32'(a_if_rdata), 32'hE0);
        chk("t1_vv_off", 32'(a_vv), 32'd0);

        // Priority among two pending sources.
        ie_wr = 1'b1; wdata = 8'h1F; nxt(); ie_wr = 1'b0;
        if_wr = 1'b1; wdata = 8'h14; reti = 1'b1; nxt(); if_wr = 1'b0; reti = 1'b0;
        chk("t2_if", 32'(a_if_rdata), 32'hF4);
        dispatch_a("t2", 1'b0);
        chk("t2_vec", 32'(a_vector), 32'h0050);
        nxt();
        chk("t2_if_clr", 32'(a_if_rdata), 32'hF0);

        // EI delay, then EI+DI together.
        ei = 1'b1; nxt(); ei = 1'b0;
        bnd = 1'b1; #1;
        chk("t3_b1", 32'(a_int_req), 32'd0);
        nxt(); #1;
        chk("t3_b2", 32'(a_int_req), 32'd1);
        chk("t3_ime", 32'(a_ime), 32'd1);
        bnd = 1'b0;
        di = 1'b1; nxt(); di = 1'b0;
        chk("t3_di", 32'(a_ime), 32'd0);
        ei = 1'b1; di = 1'b1; nxt(); ei = 1'b0; di = 1'b0;
        bnd = 1'b1; nxt(); bnd = 1'b0;
        chk("t3_eidi", 32'(a_ime), 32'd0);

        // HALT entry, wake without dispatch, HALT bug.
        if_wr = 1'b1; wdata = 8'h00; nxt(); if_wr = 1'b0;
        halt_req = 1'b1; nxt(); halt_req = 1'b0;
        chk("t4_halted", 32'(a_halted), 32'd1);
        src[1] = 1'b1; nxt(); src[1] = 1'b0;
        chk("t4_still", 32'(a_halted), 32'd1);
        nxt();
        chk("t4_wake", 32'(a_halted), 32'd0);
        chk("t4_if", 32'(a_if_rdata), 32'hE2);
        chk("t4_nodisp", 32'(a_disp_step), 32'd0);
        halt_req = 1'b1; nxt(); halt_req = 1'b0;
        chk("t4_bug", 32'(a_halt_bug), 32'd1);
        chk("t4_nohalt", 32'(a_halted), 32'd0);
        nxt();
        chk("t4_bug_off", 32'(a_halt_bug), 32'd0);

        // IE cleared mid-dispatch, then an edge racing the step-4 clear.
        reti = 1'b1; nxt(); reti = 1'b0;
        dispatch_a("t5a", 1'b1);
        chk("t5a_vec", 32'(a_vector), 32'h0000);
        nxt();
        chk("t5a_if", 32'(a_if_rdata), 32'hE2);
        ie_wr = 1'b1; wdata = 8'h1F; reti = 1'b1; nxt(); ie_wr = 1'b0; reti = 1'b0;
        dispatch_a("t5b", 1'b0);
        chk("t5b_vec", 32'(a_vector), 32'h0048);
        src[1] = 1'b1; nxt(); src[1] = 1'b0;
        chk("t5b_if", 32'(a_if_rdata), 32'hE2);

        // Eight sources, custom base/stride, reset mid-dispatch.
        rst = 1'b1; quiet(); repeat (2) nxt(); rst = 1'b0;
        ie_wr = 1'b1; wdata = 8'h80; nxt(); ie_wr = 1'b0;
        reti = 1'b1; src[7] = 1'b1; nxt(); reti = 1'b0; src[7] = 1'b0;
        chk("t6_if", 32'(b_if_rdata), 32'h80);
        bnd = 1'b1; #1;
        chk("t6_req", 32'(b_int_req), 32'd1);
        int_ack = 1'b1; nxt(); bnd = 1'b0; int_ack = 1'b0;
        repeat (4) nxt();
        chk("t6_vv", 32'(b_vv), 32'd1);
        chk("t6_vec", 32'(b_vector), 32'h011C);
        nxt();
        chk("t6_if_clr", 32'(b_if_rdata), 32'h00);
        src[7] = 1'b1; reti = 1'b1; nxt(); src[7] = 1'b0; reti = 1'b0;
        bnd = 1'b1; int_ack = 1'b1; nxt(); bnd = 1'b0; int_ack = 1'b0;
        repeat (2) nxt();
        chk("t6_pre_step", 32'(b_disp_step), 32'd2);
        rst = 1'b1; #1;
        chk("t6_rst_step", 32'(b_disp_step), 32'd0);
        chk("t6_rst_vv", 32'(b_vv), 32'd0);
        chk("t6_rst_vec", 32'(b_vector), 32'd0);
        chk("t6_rst_ime", 32'(b_ime), 32'd0);
        chk("t6_rst_if", 32'(b_if_rdata), 32'h00);
        chk("t6_rst_ie", 32'(b_ie_rdata), 32'h00);
        chk("t6_rst_halted", 32'(b_halted), 32'd0);
        repeat (3) nxt();
        chk("t6_rst_vv2", 32'(b_vv), 32'd0);

        // Randomized traffic against the model.
        rst = 1'b0;
        m_if = 0; m_ie = 0; m_prev = int'(src[4:0]); m_disp = -1; m_sel = -1;
        m_ime = 1'b0; m_arm = 1'b0; m_halt = 1'b0; m_hbug = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            bit idle, e_req, ack, n_ime, n_arm;
            int pend, rise, n_if, b, e_vec;
            idle = (m_disp < 0) && !m_halt;
            quiet();
            if ($urandom_range(7) == 0) begin
                b = int'($urandom_range(4));
                src[b] = ~src[b];
            end
            wdata    = 8'($urandom);
            if_wr    = ($urandom_range(15) == 0);
            ie_wr    = ($urandom_range(15) == 0);
            ei       = ($urandom_range(11) == 0);
            di       = ($urandom_range(23) == 0);
            bnd      = idle && ($urandom_range(2) == 0);
            reti     = idle && !bnd && ($urandom_range(19) == 0);
            halt_req = idle && !bnd && ($urandom_range(24) == 0);
            pend     = m_if & m_ie & 'h1F;
            e_req    = idle && bnd && m_ime && (pend != 0);
            int_ack  = e_req && ($urandom_range(1) == 1);
            #1;
            e_vec = (m_sel < 0) ? 0 : ((32'h40 + m_sel * 8) & 'hFFFF);
            chk("r_if", 32'(a_if_rdata), (m_if | 'hE0));
            chk("r_ie", 32'(a_ie_rdata), m_ie);
            chk("r_ime", 32'(a_ime), 32'(m_ime));
            chk("r_halted", 32'(a_halted), 32'(m_halt));
            chk("r_hbug", 32'(a_halt_bug), 32'(m_hbug));
            chk("r_req", 32'(a_int_req), 32'(e_req));
            chk("r_step", 32'(a_disp_step), (m_disp < 0) ? 0 : m_disp);
            chk("r_vv", 32'(a_vv), 32'(m_disp == 4));
            chk("r_vec", 32'(a_vector), (m_disp == 4) ? e_vec : 0);

            rise = int'(src[4:0]) & ~m_prev & 'h1F;
            n_if = m_if;
            if (m_disp == 4 && m_sel >= 0) n_if = n_if & ~(1 << m_sel);
            if (if_wr) n_if = int'(wdata) & 'h1F;
            n_if = n_if | rise;
            if (ie_wr) m_ie = int'(wdata);
            ack = e_req && int_ack;
            n_ime = m_ime; n_arm = m_arm;
            if (di) begin
                n_ime = 1'b0; n_arm = 1'b0;
            end else begin
                if (ei && m_disp < 0) n_arm = 1'b1;
                if (!ei && bnd && m_arm) begin n_ime = 1'b1; n_arm = 1'b0; end
                if (reti) n_ime = 1'b1;
            end
            if (ack) n_ime = 1'b0;
            m_hbug = 1'b0;
            if (ack) m_disp = 0;
            else if (m_disp >= 0) begin
                if (m_disp == 3) m_sel = lowest(pend);
                m_disp = (m_disp == 4) ? -1 : m_disp + 1;
            end else if (m_halt) begin
                if (pend != 0) m_halt = 1'b0;
            end else if (halt_req) begin
                if (!m_ime && pend != 0) m_hbug = 1'b1;
                else                     m_halt = 1'b1;
            end
            m_if = n_if; m_prev = int'(src[4:0]); m_ime = n_ime; m_arm = n_arm;
            nxt();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
